// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data memory responder
package dmem_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;
  function automatic logic [3:0] size_bytes(size_e s);
    return 4'd1 << s;
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian lane extraction/extension for loads and lane merge for stores
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  off,
  input  size_e       size,
  input  logic        uns,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic [63:0] wword
);
  logic [5:0]  sh;
  logic [63:0] s, m;
  assign sh = {off, 3'b000};
  assign s = word >> sh;
  assign m = size == SZ_D ? '1 : size == SZ_W ? 64'hFFFF_FFFF : size == SZ_H ? 64'hFFFF : 64'hFF;
  assign rdata = size == SZ_D ? s :
                 size == SZ_W ? {{32{~uns & s[31]}}, s[31:0]} :
                 size == SZ_H ? {{48{~uns & s[15]}}, s[15:0]} :
                                {{56{~uns & s[7]}}, s[7:0]};
  assign wword = (word & ~(m << sh)) | ((wdata & m) << sh);
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory serving one load/store at a time
// over valid/ready request and response channels.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = LATENCY > 2 ? $clog2(LATENCY) : 1;
  logic [63:0] mem [DEPTH_WORDS] = '{0: 64'd10, 1: 64'd12, 2: 64'd6, default: 64'd0};
  state_e state;
  logic [CNT_W-1:0] cnt;
  logic lw, lu, cw, cu, err, acc;
  logic [63:0] la, ld, ca, cd, rdata, wword, rsp_d;
  size_e ls, cs;
  logic [IDX_W-1:0] idx;
  // In IDLE the access (LATENCY==1 only) uses the live request; otherwise the latched copy.
  assign cw = state == S_IDLE ? req_write : lw;
  assign cu = state == S_IDLE ? req_unsigned : lu;
  assign ca = state == S_IDLE ? req_addr : la;
  assign cd = state == S_IDLE ? req_wdata : ld;
  assign cs = state == S_IDLE ? size_e'(req_size) : ls;
  assign idx = ca[IDX_W+2:3];
  assign err = (|(ca[2:0] & 3'(size_bytes(cs) - 4'd1))) || ((ca >> 3) >= 64'(DEPTH_WORDS));
  assign acc = LATENCY == 1 ? state == S_IDLE && req_valid : state == S_BUSY && cnt == '0;
  assign rsp_d = (err || cw) ? '0 : rdata;
  dmem_lane_align u_lane (
    .word (mem[idx]),
    .off  (ca[2:0]),
    .size (cs),
    .uns  (cu),
    .wdata(cd),
    .rdata(rdata),
    .wword(wword)
  );
  always_ff @(posedge clk)
    if (acc && cw && !err) mem[idx] <= wword;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      lw        <= 1'b0;
      lu        <= 1'b0;
      la        <= '0;
      ld        <= '0;
      ls        <= SZ_B;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          lw        <= req_write;
          lu        <= req_unsigned;
          la        <= req_addr;
          ld        <= req_wdata;
          ls        <= size_e'(req_size);
          cnt       <= CNT_W'(LATENCY - 1);
          req_ready <= 1'b0;
          state     <= acc ? S_RESP : S_BUSY;
          rsp_valid <= acc;
          rsp_rdata <= rsp_d;
          rsp_err   <= acc && err;
        end
        S_BUSY: if (acc) begin
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= rsp_d;
          rsp_err   <= err;
        end else cnt <= cnt - 1'b1;
        S_RESP: if (rsp_ready) begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard-driven bench for the data memory responder
module tb_data_mem_responder;
  localparam int LAT = 2;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_write = 0, req_unsigned = 0, rsp_ready = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic [1:0] req_size = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  int n_checks = 0, n_fail = 0;
  typedef struct {logic [63:0] rd; logic err;} exp_t;
  typedef struct {logic w; logic [63:0] a; logic [63:0] d; logic [1:0] sz; logic u; logic [63:0] erd; logic eerr; string nm;} row_t;
  exp_t q[$];
  always #5 clk = ~clk;
  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  task automatic drive(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz, input logic u);
    req_write = w; req_addr = a; req_wdata = d; req_size = sz; req_unsigned = u;
  endtask
  task automatic issue(input row_t r, output int waited);
    q.push_back('{rd: r.erd, err: r.eerr});
    drive(r.w, r.a, r.d, r.sz, r.u);
    req_valid = 1;
    waited = 0;
    while (!req_ready && waited < 50) begin @(negedge clk); waited++; end
    @(negedge clk);
    req_valid = 0;
  endtask
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
  endtask
  task automatic release_rsp();
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask
  task automatic test_reset();
    int lat, w;
    exp_t e;
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b, need 1 0 0 0", req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    rst = 0;
    @(negedge clk);
    drive(1, 64'h18, 64'h55, 2'd3, 0);
    req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_busy_ready: got %b need 0", req_ready); end
    rst = 1;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_midbusy: valid=%b ready=%b, need 0 1", rsp_valid, req_ready);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    issue('{w: 0, a: 64'h18, d: 0, sz: 3, u: 0, erd: 0, eerr: 0, nm: "ld_word3"}, w);
    wait_rsp(lat);
    n_checks++;
    e = q.pop_front();
    if (!rsp_valid || rsp_rdata !== e.rd || rsp_err !== e.err) begin
      n_fail++; $display("FAIL reset_word3: valid=%b rdata=%h err=%b, need 1 %h %b", rsp_valid, rsp_rdata, rsp_err, e.rd, e.err);
    end
    release_rsp();
  endtask
  task automatic test_load();
    int lat, w;
    exp_t e;
    issue('{w: 0, a: 64'h08, d: 0, sz: 3, u: 0, erd: 64'd12, eerr: 0, nm: "ld_08"}, w);
    wait_rsp(lat);
    e = q.pop_front();
    n_checks++;
    if (lat != LAT) begin n_fail++; $display("FAIL load_latency: got %0d need %0d", lat, LAT); end
    n_checks++;
    if (rsp_rdata !== e.rd || rsp_err !== e.err) begin
      n_fail++; $display("FAIL load_data: rdata=%h err=%b, need %h %b", rsp_rdata, rsp_err, e.rd, e.err);
    end
    release_rsp();
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL load_idle: valid=%b ready=%b, need 0 1", rsp_valid, req_ready);
    end
  endtask
  task automatic test_lanes();
    row_t rows[$];
    int lat, w;
    exp_t e;
    rows.push_back('{w: 1, a: 64'h11, d: 64'hFF, sz: 0, u: 0, erd: 0, eerr: 0, nm: "sb_11"});
    rows.push_back('{w: 0, a: 64'h11, d: 0, sz: 0, u: 0, erd: 64'hFFFF_FFFF_FFFF_FFFF, eerr: 0, nm: "lb_11"});
    rows.push_back('{w: 0, a: 64'h11, d: 0, sz: 0, u: 1, erd: 64'hFF, eerr: 0, nm: "lbu_11"});
    rows.push_back('{w: 0, a: 64'h10, d: 0, sz: 3, u: 0, erd: 64'hFF06, eerr: 0, nm: "ld_10"});
    rows.push_back('{w: 1, a: 64'h16, d: 64'h1111_ABCD, sz: 1, u: 0, erd: 0, eerr: 0, nm: "sh_16"});
    rows.push_back('{w: 0, a: 64'h10, d: 0, sz: 1, u: 0, erd: 64'hFFFF_FFFF_FFFF_FF06, eerr: 0, nm: "lh_10"});
    rows.push_back('{w: 0, a: 64'h10, d: 0, sz: 2, u: 1, erd: 64'h0000_FF06, eerr: 0, nm: "lwu_10"});
    rows.push_back('{w: 0, a: 64'h14, d: 0, sz: 2, u: 0, erd: 64'hFFFF_FFFF_ABCD_0000, eerr: 0, nm: "lw_14"});
    rows.push_back('{w: 0, a: 64'h10, d: 0, sz: 3, u: 0, erd: 64'hABCD_0000_0000_FF06, eerr: 0, nm: "ld_10b"});
    foreach (rows[i]) begin
      issue(rows[i], w);
      wait_rsp(lat);
      e = q.pop_front();
      n_checks++;
      if (!rsp_valid || rsp_rdata !== e.rd || rsp_err !== e.err) begin
        n_fail++; $display("FAIL lanes_%s: valid=%b rdata=%h err=%b, need 1 %h %b", rows[i].nm, rsp_valid, rsp_rdata, rsp_err, e.rd, e.err);
      end
      release_rsp();
    end
  endtask
  task automatic test_errors();
    row_t rows[$];
    int lat, w;
    exp_t e;
    rows.push_back('{w: 1, a: 64'h02, d: 64'h77, sz: 2, u: 0, erd: 0, eerr: 1, nm: "sw_02"});
    rows.push_back('{w: 0, a: 64'h00, d: 0, sz: 3, u: 0, erd: 64'd10, eerr: 0, nm: "ld_00"});
    rows.push_back('{w: 0, a: 64'h800, d: 0, sz: 3, u: 0, erd: 0, eerr: 1, nm: "ld_800"});
    rows.push_back('{w: 0, a: 64'h03, d: 0, sz: 1, u: 0, erd: 0, eerr: 1, nm: "lh_03"});
    rows.push_back('{w: 1, a: 64'h1000_0000_0000_0008, d: 64'h99, sz: 3, u: 0, erd: 0, eerr: 1, nm: "sd_hi"});
    rows.push_back('{w: 0, a: 64'h08, d: 0, sz: 3, u: 0, erd: 64'd12, eerr: 0, nm: "ld_08"});
    rows.push_back('{w: 0, a: 64'h7F8, d: 0, sz: 3, u: 0, erd: 0, eerr: 0, nm: "ld_7f8"});
    foreach (rows[i]) begin
      issue(rows[i], w);
      wait_rsp(lat);
      e = q.pop_front();
      n_checks++;
      if (!rsp_valid || lat != LAT || rsp_rdata !== e.rd || rsp_err !== e.err) begin
        n_fail++; $display("FAIL err_%s: valid=%b lat=%0d rdata=%h err=%b, need 1 %0d %h %b", rows[i].nm, rsp_valid, lat, rsp_rdata, rsp_err, LAT, e.rd, e.err);
      end
      release_rsp();
    end
  endtask
  task automatic test_backpressure();
    int lat, w;
    exp_t e;
    issue('{w: 0, a: 64'h00, d: 0, sz: 3, u: 0, erd: 64'd10, eerr: 0, nm: "ld_00"}, w);
    wait_rsp(lat);
    e = q.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rd || rsp_err !== e.err || req_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: valid=%b rdata=%h err=%b ready=%b, need 1 %h %b 0", i, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rd, e.err);
      end
      drive(1, 64'h00, 64'h99, 2'd3, 0);
      req_valid = (i % 2 == 0);
      @(negedge clk);
    end
    req_valid = 0;
    release_rsp();
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: valid=%b ready=%b, need 0 1", rsp_valid, req_ready);
    end
    issue('{w: 0, a: 64'h00, d: 0, sz: 3, u: 0, erd: 64'd10, eerr: 0, nm: "ld_00"}, w);
    wait_rsp(lat);
    e = q.pop_front();
    n_checks++;
    if (!rsp_valid || rsp_rdata !== e.rd || rsp_err !== e.err) begin
      n_fail++; $display("FAIL bp_ignored_store: valid=%b rdata=%h err=%b, need 1 %h %b", rsp_valid, rsp_rdata, rsp_err, e.rd, e.err);
    end
    release_rsp();
  endtask
  task automatic test_back_to_back();
    int lat, w;
    exp_t e;
    rsp_ready = 1;
    issue('{w: 1, a: 64'h20, d: 64'h1234, sz: 3, u: 0, erd: 0, eerr: 0, nm: "sd_20"}, w);
    wait_rsp(lat);
    e = q.pop_front();
    n_checks++;
    if (!rsp_valid || rsp_rdata !== e.rd || rsp_err !== e.err) begin
      n_fail++; $display("FAIL b2b_store: valid=%b rdata=%h err=%b, need 1 %h %b", rsp_valid, rsp_rdata, rsp_err, e.rd, e.err);
    end
    q.push_back('{rd: 64'h1234, err: 1'b0});
    drive(0, 64'h20, 0, 2'd3, 0);
    req_valid = 1;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_bubble: valid=%b ready=%b, need 0 1", rsp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 0;
    wait_rsp(lat);
    e = q.pop_front();
    n_checks++;
    if (!rsp_valid || lat != LAT || rsp_rdata !== e.rd || rsp_err !== e.err) begin
      n_fail++; $display("FAIL b2b_load: valid=%b lat=%0d rdata=%h err=%b, need 1 %0d %h %b", rsp_valid, lat, rsp_rdata, rsp_err, LAT, e.rd, e.err);
    end
    @(negedge clk);
    rsp_ready = 0;
    n_checks++;
    if (q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d need 0", q.size()); end
  endtask
  initial begin
    test_reset();
    test_load();
    test_lanes();
    test_errors();
    test_backpressure();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
